// File: rtl/key_led_ctrl.sv
// ---------------------------------------------------------------------------
// key_led_ctrl
//   Sequences the board LED from one mechanical key.
//   - Two-flop synchroniser on the raw key (both flops idle high).
//   - Debounce FSM: IDLE -> PFILT -> DOWN -> RFILT. Each filter state needs
//     DEB_CNT_MAX+1 further stable samples. A bounce restarts the filter.
//   - One-cycle key_flag per confirmed press.
//   - Each key_flag steps the mode: OFF(0) -> ON(1) -> BLINK(2) -> OFF.
//   - The LED follows the mode one edge later. In BLINK, the LED starts lit
//     and toggles every BLINK_CNT_MAX+1 clocks.
//   Optional feature macro: KEY_LONG_PRESS_EN. When it is defined, holding
//   the key LONG_CNT_MAX+1 clocks in DOWN forces the mode to OFF, once per
//   press.
//
// Parameters
//   DEB_CNT_MAX   : debounce hold, in clocks minus one
//   BLINK_CNT_MAX : blink half-period, in clocks minus one
//   LONG_CNT_MAX  : long-press threshold, in clocks minus one
// Ports
//   sys_clk   in  1 : system clock (the only clock)
//   sys_rst_n in  1 : asynchronous active-low reset
//   key_in    in  1 : raw key, active-low, asynchronous to sys_clk
//   led_out   out 1 : LED drive, 1 = lit
//   mode      out 2 : 0 = OFF, 1 = ON, 2 = BLINK
//   key_flag  out 1 : one-cycle pulse per debounced press
// ---------------------------------------------------------------------------
module key_led_ctrl #(
  parameter logic [19:0] DEB_CNT_MAX   = 20'd999_999,
  parameter logic [24:0] BLINK_CNT_MAX = 25'd24_999_999,
  parameter logic [25:0] LONG_CNT_MAX  = 26'd49_999_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_in,
  output logic       led_out,
  output logic [1:0] mode,
  output logic       key_flag
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PFILT = 2'd1,
    DOWN  = 2'd2,
    RFILT = 2'd3
  } state_t;

  logic        r_sync1;
  logic        r_sync2;
  logic        w_key_s;
  state_t      r_state;
  state_t      w_state_nxt;
  logic [19:0] r_cnt;
  logic [19:0] w_cnt_nxt;
  logic        r_key_flag;
  logic        w_flag_nxt;
  logic [1:0]  r_mode;
  logic [1:0]  w_mode_nxt;
  logic        r_led;
  logic        w_led_nxt;
  logic [24:0] r_blink_cnt;
  logic [24:0] w_blink_cnt_nxt;
  logic        r_in_blink;
  logic        w_in_blink_nxt;
  logic        w_long_s;

  // Two-flop synchroniser; both flops idle high (key released)
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_key_s = r_sync2;

  // Debounce FSM state, filter counter and press pulse registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= 20'd0;
      r_key_flag <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_key_flag <= w_flag_nxt;
    end
  end

  // Debounce next-state logic. The counter clears on every state change.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_flag_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_key_s) begin
          w_state_nxt = PFILT;
          w_cnt_nxt   = 20'd0;
        end else begin
          w_cnt_nxt   = 20'd0;
        end
      end
      PFILT: begin
        if (w_key_s) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 20'd0;
        end else if (r_cnt == DEB_CNT_MAX) begin
          w_state_nxt = DOWN;
          w_cnt_nxt   = 20'd0;
          w_flag_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + 20'd1;
        end
      end
      DOWN: begin
        if (w_key_s) begin
          w_state_nxt = RFILT;
          w_cnt_nxt   = 20'd0;
        end else begin
          w_cnt_nxt   = 20'd0;
        end
      end
      RFILT: begin
        if (!w_key_s) begin
          w_state_nxt = DOWN;
          w_cnt_nxt   = 20'd0;
        end else if (r_cnt == DEB_CNT_MAX) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 20'd0;
        end else begin
          w_cnt_nxt   = r_cnt + 20'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 20'd0;
      end
    endcase
  end

`ifdef KEY_LONG_PRESS_EN
  logic [25:0] r_hold_cnt;
  logic        r_long_fired;
  logic        r_long_flag;

  // Hold timer in DOWN. The fired latch is cleared only back in IDLE, so
  // release bounces cannot re-arm the long press.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_hold_cnt   <= 26'd0;
      r_long_fired <= 1'b0;
      r_long_flag  <= 1'b0;
    end else begin
      r_long_flag <= 1'b0;
      if (r_state == DOWN) begin
        if (r_hold_cnt == LONG_CNT_MAX) begin
          if (!r_long_fired) begin
            r_long_flag  <= 1'b1;
            r_long_fired <= 1'b1;
          end
        end else begin
          r_hold_cnt <= r_hold_cnt + 26'd1;
        end
      end else begin
        r_hold_cnt <= 26'd0;
        if (r_state == IDLE) begin
          r_long_fired <= 1'b0;
        end
      end
    end
  end

  assign w_long_s = r_long_flag;
`else
  logic w_unused_long;

  assign w_unused_long = ^LONG_CNT_MAX;
  assign w_long_s      = 1'b0;
`endif

  // Mode next-state logic: a long press overrides, otherwise step on press
  always_comb begin
    w_mode_nxt = r_mode;
    if (w_long_s) begin
      w_mode_nxt = 2'd0;
    end else if (r_key_flag) begin
      case (r_mode)
        2'd0:    w_mode_nxt = 2'd1;
        2'd1:    w_mode_nxt = 2'd2;
        2'd2:    w_mode_nxt = 2'd0;
        default: w_mode_nxt = 2'd0;
      endcase
    end else begin
      w_mode_nxt = r_mode;
    end
  end

  // Mode register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_mode <= 2'd0;
    end else begin
      r_mode <= w_mode_nxt;
    end
  end

  // LED next-state logic. It reads the registered mode, so the LED lags the
  // mode by one edge. On BLINK entry the LED restarts lit.
  always_comb begin
    w_led_nxt       = r_led;
    w_blink_cnt_nxt = 25'd0;
    w_in_blink_nxt  = 1'b0;
    case (r_mode)
      2'd0: w_led_nxt = 1'b0;
      2'd1: w_led_nxt = 1'b1;
      2'd2: begin
        w_in_blink_nxt = 1'b1;
        if (!r_in_blink) begin
          w_led_nxt       = 1'b1;
          w_blink_cnt_nxt = 25'd0;
        end else if (r_blink_cnt == BLINK_CNT_MAX) begin
          w_led_nxt       = ~r_led;
          w_blink_cnt_nxt = 25'd0;
        end else begin
          w_blink_cnt_nxt = r_blink_cnt + 25'd1;
        end
      end
      default: w_led_nxt = 1'b0;
    endcase
  end

  // LED, blink timer and BLINK-entry tracking registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_led       <= 1'b0;
      r_blink_cnt <= 25'd0;
      r_in_blink  <= 1'b0;
    end else begin
      r_led       <= w_led_nxt;
      r_blink_cnt <= w_blink_cnt_nxt;
      r_in_blink  <= w_in_blink_nxt;
    end
  end

  assign led_out  = r_led;
  assign mode     = r_mode;
  assign key_flag = r_key_flag;

endmodule

// File: tb/tb_key_led_ctrl.sv
// ---------------------------------------------------------------------------
// tb_key_led_ctrl
//   Self-checking bench for key_led_ctrl with small timing parameters.
//   The reference model works on run lengths of the synchronised key and
//   on elapsed time in BLINK. Directed steps follow the press, bounce, mode
//   cycle and reset scenarios. A randomized key phase follows them.
// ---------------------------------------------------------------------------
module tb_key_led_ctrl;

  localparam int DEB   = 4;
  localparam int BLINK = 9;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       key_in    = 1'b1;
  logic       led_out;
  logic [1:0] mode;
  logic       key_flag;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_s1, m_s2;
  bit m_armed;
  int m_low, m_high;
  bit m_flag;
  int m_mode;
  bit m_led;
  int m_edge, m_enter, m_seen_prev;

  key_led_ctrl #(
    .DEB_CNT_MAX  (20'd4),
    .BLINK_CNT_MAX(25'd9),
    .LONG_CNT_MAX (26'd49)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_in   (key_in),
    .led_out  (led_out),
    .mode     (mode),
    .key_flag (key_flag)
  );

  always #10 sys_clk = ~sys_clk;

  task automatic model_reset();
    m_s1 = 1'b1; m_s2 = 1'b1;
    m_armed = 1'b1; m_low = 0; m_high = 0;
    m_flag = 1'b0; m_mode = 0; m_led = 1'b0;
    m_edge = 0; m_enter = 0; m_seen_prev = 0;
  endtask

  // Model state after one edge sampling key value k
  task automatic model_step(input bit k);
    int seen;
    bit ks;
    seen = m_mode;
    ks   = m_s2;
    if (seen == 2 && m_seen_prev != 2) m_enter = m_edge;
    if (seen == 0)      m_led = 1'b0;
    else if (seen == 1) m_led = 1'b1;
    else                m_led = (((m_edge - m_enter) / (BLINK + 1)) % 2) == 0;
    m_seen_prev = seen;
    if (m_flag) m_mode = (m_mode + 1) % 3;
    m_flag = 1'b0;
    // A press needs DEB+2 consecutive low samples while armed. Re-arming
    // needs DEB+2 consecutive high samples.
    if (m_armed) begin
      if (!ks) begin
        m_low++;
        if (m_low == DEB + 2) begin
          m_flag = 1'b1; m_armed = 1'b0; m_high = 0;
        end
      end else begin
        m_low = 0;
      end
    end else begin
      if (ks) begin
        m_high++;
        if (m_high == DEB + 2) begin
          m_armed = 1'b1; m_low = 0;
        end
      end else begin
        m_high = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = k;
    m_edge++;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock with model tracking; called and returns at a negedge
  task automatic step(input bit k);
    key_in = k;
    model_step(k);
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk("model_key_flag", key_flag, m_flag);
    chk("model_mode", mode, m_mode[1:0]);
    chk("model_led", led_out, m_led);
  endtask

  // One clock without the model (long-hold scenario only)
  task automatic drive_only(input bit k);
    key_in = k;
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic press(input int lo, input int hi);
    for (int i = 0; i < lo; i++) step(1'b0);
    for (int i = 0; i < hi; i++) step(1'b1);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge sys_clk);
    chk("reset_led", led_out, 2'd0);
    chk("reset_mode", mode, 2'd0);
    chk("reset_flag", key_flag, 2'd0);
    sys_rst_n = 1'b1;

    // Idle with key released
    for (int i = 0; i < 100; i++) step(1'b1);
    chk("idle_mode", mode, 2'd0);
    chk("idle_led", led_out, 2'd0);

    // Bounce: 3 low, 1 high, 3 low, then released
    press(3, 1);
    press(3, 20);
    chk("bounce_mode", mode, 2'd0);

    // Clean press: pulse after edge 7, mode 1 after edge 8, LED after edge 9
    for (int k = 0; k < 20; k++) begin
      step(1'b0);
      chk("press_flag", key_flag, (k == 7) ? 2'd1 : 2'd0);
      chk("press_mode", mode, (k >= 8) ? 2'd1 : 2'd0);
      chk("press_led", led_out, (k >= 9) ? 2'd1 : 2'd0);
    end
    for (int i = 0; i < 20; i++) step(1'b1);

    // Second press: BLINK, LED lit then toggling every 10 cycles
    for (int k = 0; k < 40; k++) begin
      step(k < 8 ? 1'b0 : 1'b1);
      chk("blink_mode", mode, (k >= 8) ? 2'd2 : 2'd1);
      if (k < 9) chk("blink_led", led_out, 2'd1);
      else       chk("blink_led", led_out, ((((k - 9) / 10) % 2) == 0) ? 2'd1 : 2'd0);
    end

    // Third press: back to OFF
    for (int k = 0; k < 25; k++) begin
      step(k < 8 ? 1'b0 : 1'b1);
      chk("off_mode", mode, (k >= 8) ? 2'd0 : 2'd2);
      if (k >= 9) chk("off_led", led_out, 2'd0);
    end

    // Reach BLINK again, then reset mid-blink with the key held
    press(8, 20);
    press(8, 15);
    chk("preblink_mode", mode, 2'd2);
    key_in = 1'b0;
    sys_rst_n = 1'b0;
    #1;
    chk("rst_led", led_out, 2'd0);
    chk("rst_mode", mode, 2'd0);
    chk("rst_flag", key_flag, 2'd0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    model_reset();
    sys_rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step(1'b0);
      chk("rst_press_flag", key_flag, (k == 7) ? 2'd1 : 2'd0);
    end
    for (int i = 0; i < 20; i++) step(1'b1);

    // Randomized key runs, 1..12 cycles each
    for (int r = 0; r < 250; r++) begin
      bit lvl;
      int len;
      lvl = 1'($urandom_range(1, 0));
      len = int'($urandom_range(12, 1));
      for (int i = 0; i < len; i++) step(lvl);
    end

`ifdef KEY_LONG_PRESS_EN
    // Long hold: ON after edge 8, forced OFF after edge 58, then stable
    sys_rst_n = 1'b0;
    key_in = 1'b1;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int k = 0; k < 80; k++) begin
      drive_only(1'b0);
      chk("long_mode", mode, (k >= 8 && k < 58) ? 2'd1 : 2'd0);
    end
    for (int i = 0; i < 20; i++) drive_only(1'b1);
    chk("long_after_mode", mode, 2'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_led_ctrl.md
# key_led_ctrl

Controller that sequences the board LED from a single mechanical key. It synchronises and debounces `key_in`, produces a one-cycle press pulse, and steps the LED through OFF → ON → BLINK on each confirmed press. It replaces the direct key-to-LED register path in the key/LED demo designs and is the block that drives `led_out` at top level.

## Interface
Parameters:
- `DEB_CNT_MAX`, default 20'd999_999: debounce hold in clocks minus one; 20 ms at 50 MHz.
- `BLINK_CNT_MAX`, default 25'd24_999_999: BLINK half-period in clocks minus one; 0.5 s at 50 MHz.
- `LONG_CNT_MAX`, default 26'd49_999_999: long-press threshold in clocks minus one; 1 s. Used only when `KEY_LONG_PRESS_EN` is defined.

Ports:
- `sys_clk` input 1: system clock, 50 MHz; the only clock.
- `sys_rst_n` input 1: asynchronous, active-low reset.
- `key_in` input 1: raw key, active-low (0 = pressed), asynchronous to `sys_clk`.
- `led_out` output 1: LED drive, 1 = lit.
- `mode` output 2: current LED mode; 0 = OFF, 1 = ON, 2 = BLINK.
- `key_flag` output 1: one-cycle pulse per debounced press.

## Operation
- Synchroniser: two flops, both reset to 1; the second flop output is `key_s`.
- Debounce FSM, reset state `IDLE`, with filter counter `cnt`:
  - `IDLE`: `key_s`=0 → `PFILT`, `cnt`=0.
  - `PFILT`: `key_s`=1 → `IDLE`. `cnt`==`DEB_CNT_MAX` → `DOWN`, `key_flag`=1 for one cycle. Otherwise `cnt`++.
  - `DOWN`: `key_s`=1 → `RFILT`, `cnt`=0.
  - `RFILT`: `key_s`=0 → `DOWN`. `cnt`==`DEB_CNT_MAX` → `IDLE`. Otherwise `cnt`++.
  - `cnt` is cleared on every state change.
- A bounce inside either filter window restarts that filter. It produces no pulse.
- Mode register advances on `key_flag`: 0→1, 1→2, 2→0. Illegal value 3 → 0.
- LED:
  - `mode` 0: `led_out`=0.
  - `mode` 1: `led_out`=1.
  - `mode` 2: on entry, `led_out`=1 and `blink_cnt`=0. After that, `blink_cnt` counts to `BLINK_CNT_MAX`, then `led_out` toggles and `blink_cnt` wraps to 0.
  - `blink_cnt` is held at 0 when `mode`≠2.
- Arithmetic: all counters are unsigned. Compare for equality with their MAX and never run past it.

## Timing
- Reset values: `led_out`=0, `mode`=0, `key_flag`=0, FSM=`IDLE`, all counters 0, synchroniser flops 1.
- Press latency: the edge that first samples `key_in`=0 is edge 0. `key_flag` is high for exactly the cycle after edge `DEB_CNT_MAX`+3.
- `mode` changes on the edge where `key_flag` is sampled high, one edge after `key_flag` rises.
- `led_out` follows `mode` one edge later.
- Release produces no pulse. A new press is accepted only after `RFILT` completes and the FSM is back in `IDLE`.
- Reset asserted mid-press or mid-blink forces all reset values immediately.
  - After release of reset, a key still held low counts as a fresh press.
- A press landing on the same edge as a blink toggle: the mode change wins. `led_out` follows the new mode.

## Configuration
- `KEY_LONG_PRESS_EN` defined:
  - In `DOWN`, `hold_cnt` counts from 0. When it reaches `LONG_CNT_MAX`, `mode` is forced to 0 on the next edge.
  - This fires at most once per press.
  - `hold_cnt` clears when the FSM leaves `DOWN`.
  - The short-press `key_flag` of that press has already advanced `mode`; the long press then overrides it to 0.
- `KEY_LONG_PRESS_EN` undefined:
  - No `hold_cnt` register exists and `LONG_CNT_MAX` is ignored.
  - Holding the key has no effect beyond the single press.

## Test plan
Bench parameters: `DEB_CNT_MAX`=4, `BLINK_CNT_MAX`=9, `LONG_CNT_MAX`=49; 20 ns clock.
- Reset only, `key_in`=1 for 100 cycles → `led_out`=0, `mode`=0, `key_flag` never high.
- Clean press held for 20 cycles, then released → exactly one `key_flag` pulse, in the cycle after edge 7. `mode` becomes 1. `led_out`=1 one edge later.
- Bounce: `key_in` low 3 cycles, high 1, low 3, high → no `key_flag`; `mode` stays 0.
- Three clean presses, each separated by ≥10 released cycles → `mode` goes 1, 2, 0.
  - In `mode` 2, `led_out` is 1, then toggles every 10 cycles.
  - In `mode` 0, `led_out`=0.
- In `mode` 2, assert `sys_rst_n`=0 mid-blink → `led_out`=0 and `mode`=0 immediately.
  - Release reset with key held low → one `key_flag`, at the cycle after edge 7 counted from the first post-reset sample.
- With `KEY_LONG_PRESS_EN`: hold the key 80 cycles → `mode` goes to 1 on the press, then to 0 after 50 cycles in `DOWN`. No further change until release.
